// File: rtl/instr_pkg.sv
// instr_pkg: shared types and constants for the SPI instruction decoder and register file
package instr_pkg;
   localparam int DEF_ADDR_W = 6;
   localparam int DEF_DATA_W = 8;
   localparam int RW_BIT     = 7;
   localparam int BURST_BIT  = 6;
   typedef enum logic [1:0] {IDLE, RD, DATA, WR} state_t;
endpackage

// File: rtl/instr_dcd.sv
// instr_dcd: turns SPI bridge bytes into single-cycle register-file read/write accesses
module instr_dcd
   import instr_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cs_n,
   input  logic              byte_sync,
   input  logic [DATA_W-1:0] data_in,
   output logic [DATA_W-1:0] data_out,
   output logic              read,
   output logic              write,
   output logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] data_read,
   output logic [DATA_W-1:0] data_write,
   output logic              ovr
);
   state_t            state_q, state_d;
   logic              rw_q, rw_d, burst_q, burst_d, ovr_q, ovr_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] data_write_q, data_write_d, data_out_q, data_out_d;
   logic [ADDR_W-1:0] addr_inc;
   assign addr_inc = burst_q ? addr_q + ADDR_W'(1) : addr_q;
   always_comb begin
      state_d      = state_q;
      rw_d         = rw_q;
      burst_d      = burst_q;
      addr_d       = addr_q;
      data_write_d = data_write_q;
      data_out_d   = data_out_q;
      ovr_d        = 1'b0;
      if (cs_n) begin
         state_d = IDLE;
         burst_d = 1'b0;
      end else begin
         case (state_q)
            IDLE: if (byte_sync) begin
               rw_d    = data_in[RW_BIT];
               burst_d = data_in[BURST_BIT];
               addr_d  = data_in[ADDR_W-1:0];
               state_d = data_in[RW_BIT] ? DATA : RD;
            end
            RD: begin
               data_out_d = data_read;
               ovr_d      = byte_sync;
               state_d    = DATA;
            end
            DATA: if (byte_sync) begin
               data_write_d = rw_q ? data_in : data_write_q;
               addr_d       = rw_q ? addr_q : addr_inc;
               state_d      = rw_q ? WR : (burst_q ? RD : IDLE);
            end
            WR: begin
               ovr_d   = byte_sync;
               addr_d  = addr_inc;
               state_d = burst_q ? DATA : IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         rw_q         <= 1'b0;
         burst_q      <= 1'b0;
         ovr_q        <= 1'b0;
         addr_q       <= '0;
         data_write_q <= '0;
         data_out_q   <= '0;
      end else begin
         state_q      <= state_d;
         rw_q         <= rw_d;
         burst_q      <= burst_d;
         ovr_q        <= ovr_d;
         addr_q       <= addr_d;
         data_write_q <= data_write_d;
         data_out_q   <= data_out_d;
      end
   end
   assign read       = (state_q == RD);
   assign write      = (state_q == WR);
   assign addr       = addr_q;
   assign data_write = data_write_q;
   assign data_out   = data_out_q;
   assign ovr        = ovr_q;
endmodule

// File: doc/instr_dcd.md
Name: instr_dcd

Overview:
- Upstream neighbour of the register file. Converts the SPI bridge's received byte stream into single-cycle read/write accesses on the register-file bus: addr, read, write, data_write, data_read.
- Returns read data to the bridge for shift-out.
- Supports single and auto-incrementing burst transactions, framed by chip select.

Parameters:
- ADDR_W, 6, register address width.
- DATA_W, 8, byte width on both bridge and register bus.

Ports:
- clk  in  1  peripheral clock
- rst_n  in  1  asynchronous active-low reset
- cs_n  in  1  SPI chip select, synchronised to clk; high means no transaction
- byte_sync  in  1  one-cycle strobe: data_in holds a newly received byte
- data_in  in  DATA_W  received byte from the SPI bridge
- data_out  out  DATA_W  byte the bridge shifts out on the next SPI byte
- read  out  1  register read strobe
- write  out  1  register write strobe
- addr  out  ADDR_W  register address
- data_read  in  DATA_W  combinational read data from the register file
- data_write  out  DATA_W  write data to the register file
- ovr  out  1  one-cycle pulse: a byte was dropped (protocol overrun)

Behaviour:
- Reset is asynchronous: clk is the clock, rst_n is active-low. Reset values: state IDLE; read=0, write=0, ovr=0; addr=0, data_write=0, data_out=0; burst flag 0, rw flag 0.
- Instruction byte layout: bit7 = rw (1 write, 0 read); bit6 = burst; bits5:0 = addr.
- States: IDLE, RD, DATA, WR.
- read = (state==RD). write = (state==WR). Both are decoded from registered state, so they are glitch-free and exactly one cycle long per access.
- IDLE + byte_sync (cs_n=0):
  - Latch rw, burst and addr from data_in.
  - If rw=0 go to RD, else go to DATA.
- RD:
  - read=1 with addr stable.
  - At the clock edge, data_out <= data_read. Next state is DATA.
  - Latency: read strobe 1 cycle after the instruction byte_sync; data_out valid 2 cycles after it.
- DATA + byte_sync:
  - Write transaction: data_write <= data_in, go to WR.
  - Read transaction: the byte is a dummy. If burst=1, addr <= addr+1 and go to RD; otherwise go to IDLE.
- WR:
  - write=1 with addr and data_write stable. The write strobe appears 1 cycle after the data byte_sync.
  - If burst=1, addr <= addr+1 and go to DATA; otherwise go to IDLE.
- Address increment wraps modulo 2^ADDR_W (6'h3F+1 = 6'h00). No saturation, no flag.
- cs_n=1:
  - Next state is IDLE from any state; burst is cleared. This aborts any pending access.
  - A strobe already asserted in the current cycle completes; no new strobe is issued.
  - byte_sync is ignored while cs_n=1.
  - data_out holds its value.
- byte_sync in RD or WR state (spacing under 3 clk):
  - The byte is dropped and ovr pulses for 1 cycle.
  - The current access completes normally.
- data_out changes only in RD. Writes never modify it.
- read and write are never asserted in the same cycle.

Decomposition:
- Shared package instr_pkg:
  - state enum (IDLE, RD, DATA, WR);
  - instruction bit positions RW_BIT=7, BURST_BIT=6;
  - ADDR_W/DATA_W defaults, shared with the register file.
- Single module; no sub-module is warranted.
- Address incrementer and state register are local to this module.

Test Plan:
- Single write: cs_n=0, bytes 0x80 then 0x34 -> one write pulse 1 cycle after the second byte_sync, addr=0x00, data_write=0x34; read never asserted.
- Single read: bytes 0x03 then dummy 0x00, register file drives data_read=0x12 at addr 0x03 -> read pulse 1 cycle after the first byte_sync, data_out=0x12 the following cycle, return to IDLE after the dummy byte.
- Burst write with wrap: bytes 0xFF, 0x11, 0x22 -> write addr 0x3F data 0x11, then write addr 0x00 data 0x22.
- Burst read: bytes 0x48, dummy, dummy, with data_read = 0xA0 + addr -> read pulses at addr 0x08 then 0x09; data_out sequence 0xA8, then 0xA9.
- Abort: bytes 0x85, then cs_n=1 before any data byte, then cs_n=0 with bytes 0x01, 0x00 -> no write ever; fresh read at addr 0x01 works.
- Overrun plus reset: byte_sync raised in the cycle state=RD -> ovr=1 for 1 cycle, byte dropped, data_out still loaded. Assert rst_n=0 mid-burst -> all outputs 0 immediately, state IDLE.
